// File: rtl/alu_serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, WIDTH clocks per result.
// Define ALU_SERIAL_FLAGS_EN to build the overflow/zero flag logic; otherwise both flags read 0.
module alu_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] ps_q;
    logic [WIDTH-1:0] ps_d;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             c_d;
    logic             s_bit;
    logic             last_bit;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;

    always_comb begin
        s_bit    = a_q[0] ^ b_q[0] ^ c_q;
        c_d      = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        ps_d     = {s_bit, ps_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= opa;
                        b_q     <= opb;
                        c_q     <= cin;
                        ps_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    ps_q  <= ps_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum_q   <= ps_d;
                        cout_q  <= c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // On the last bit c_q is the carry into the MSB and c_d the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state_q == SHIFT && last_bit) begin
            ovf_q  <= c_q ^ c_d;
            zero_q <= (ps_d == '0);
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_alu_serial_adder.sv
// Directed bench for alu_serial_adder (WIDTH=8): vector table plus multi-cycle corner sequences.
module tb_alu_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;
    logic       zero;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;

`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
        logic       z;
    } vec_t;

    vec_t vecs [8];

    alu_serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opa      (opa),
        .opb      (opb),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        opa   = a;
        opb   = b;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy && done) overlap++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int first_t;
        int t1, t2;
        logic [7:0] s1, s2;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'hFC, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        opa   = '0;
        opb   = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci);
            check($sformatf("v%0d busy", i), 32'(busy), 32'd1);
            opa = ~vecs[i].a;
            opb = ~vecs[i].b;
            cin = ~vecs[i].ci;
            wait_done(lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd8);
            check($sformatf("v%0d sum", i), 32'(sum), 32'(vecs[i].s));
            check($sformatf("v%0d cout", i), 32'(cout), 32'(vecs[i].co));
            check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ov & FLAGS));
            check($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].z & FLAGS));
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), 32'(done), 32'd0);
        end

        // start during SHIFT is ignored; results are held until completion
        start_op(8'h05, 8'h03, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        opa   = 8'hFF;
        opb   = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone   = 0;
        first_t = 0;
        for (int cyc = 4; cyc <= 14; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 4) check("ign held sum", 32'(sum), 32'h4B);
            if (busy && done) overlap++;
            if (done) begin
                ndone++;
                if (first_t == 0) first_t = cyc;
            end
        end
        check("ign done count", 32'(ndone), 32'd1);
        check("ign done cycle", 32'(first_t), 32'd8);
        check("ign sum", 32'(sum), 32'h08);

        // start held across done: back-to-back accepted in DONE
        @(negedge clk);
        opa   = 8'h01;
        opb   = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        opa = 8'h02;
        opb = 8'h02;
        t1 = 0;
        t2 = 0;
        s1 = '0;
        s2 = '0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(posedge clk);
            #1;
            if (busy && done) overlap++;
            if (done) begin
                if (t1 == 0) begin
                    t1 = cyc;
                    s1 = sum;
                end else if (t2 == 0) begin
                    t2 = cyc;
                    s2 = sum;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b first done", 32'(t1), 32'd8);
        check("b2b second done", 32'(t2), 32'd17);
        check("b2b first sum", 32'(s1), 32'h02);
        check("b2b second sum", 32'(s2), 32'h04);
        repeat (2) @(posedge clk);

        // asynchronous reset mid-operation
        start_op(8'h55, 8'hAA, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst no done", 32'(ndone), 32'd0);
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(lat);
        check("post-rst latency", 32'(lat), 32'd8);
        check("post-rst sum", 32'(sum), 32'h30);
        check("busy/done overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_adder.md
# alu_serial_adder

Bit-serial adder stage directly downstream of the ALU operand-select stage. Captures operand A, the selected operand B and the carry-in produced for add, subtract, pass and increment, then adds them LSB-first, one bit per clock. Presents a registered sum, carry-out and status flags with a single-cycle `done` pulse. Trades latency for a single full-adder cell in the datapath.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is `WIDTH` ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset; one clock domain.
- `start`  input  1  request to begin an addition; sampled only in IDLE or DONE.
- `opa`  input  WIDTH  operand A.
- `opb`  input  WIDTH  operand B, already inverted or zeroed upstream.
- `cin`  input  1  carry-in (1 for subtract and increment).
- `busy`  output  1  high while bits are being processed (state SHIFT).
- `done`  output  1  one-cycle pulse when `sum` and the flags are valid.
- `sum`  output  WIDTH  registered result; held until the next completion.
- `cout`  output  1  carry out of the MSB.
- `overflow`  output  1  signed overflow: carry into the MSB XOR `cout`.
- `zero`  output  1  high when `sum` == 0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, `start`=1:
  - load the A and B shift registers from `opa` and `opb`;
  - load the carry register from `cin`;
  - clear the bit counter;
  - go to SHIFT.
- SHIFT, each edge:
  - s = a0 ^ b0 ^ c;
  - c' = majority(a0, b0, c);
  - shift s into the MSB of the partial-sum register, which shifts right;
  - shift A and B right;
  - increment the counter.
- SHIFT, on the edge that processes bit WIDTH-1:
  - copy the partial sum to `sum`, the final carry to `cout`, and update `overflow` and `zero`;
  - go to DONE.
- DONE lasts exactly one cycle:
  - `start`=1 starts a new operation, same as from IDLE (back-to-back);
  - otherwise go to IDLE.
- `start` in SHIFT is ignored; no queuing and no error flag.
- Operand inputs are sampled only on the start edge. Changes afterwards have no effect.
- Arithmetic is modulo 2^WIDTH. `cout` is the unsigned carry or not-borrow. `overflow` follows two's-complement semantics.
- `sum`, `cout`, `overflow` and `zero` change only on the completion edge. They are never updated mid-operation.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `overflow`=0, `zero`=0; state IDLE; counter 0.
- Let E0 be the edge where `start` is accepted. Then:
  - `busy` is high from E0 to E(WIDTH);
  - results update at E(WIDTH);
  - `done` is high from E(WIDTH) to E(WIDTH+1).
- Latency from start to `done` is WIDTH cycles. With `start` held high, throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high together.
- Reset asserted mid-operation takes effect immediately and asynchronously. It aborts the operation, applies all reset values, and produces no `done`.
- Deassert `rst_n` synchronously to `clk` externally. The first `start` is accepted on the first edge after deassertion.

## Configuration
- Macro `ALU_SERIAL_FLAGS_EN`.
- Defined: the `overflow` and `zero` logic is built as specified above.
- Undefined:
  - `overflow` and `zero` are tied to 0, and the ports remain present;
  - the MSB carry-in register and the zero-detect logic are removed;
  - `sum`, `cout`, `busy` and `done` behave identically.

## Test plan
- `opa`=0x05, `opb`=0x03, `cin`=0 → `done` 8 cycles after the start edge; `sum`=0x08, `cout`=0, `overflow`=0, `zero`=0.
- Subtract 5−3 (`opa`=0x05, `opb`=0xFC, `cin`=1) → `sum`=0x02, `cout`=1. Then `opa`=0x7F, `opb`=0x01, `cin`=0 → `sum`=0x80, `overflow`=1 (0 if the macro is undefined).
- `opa`=0xFF, `opb`=0x00, `cin`=1 → `sum`=0x00, `cout`=1, `zero`=1.
- `start` pulsed again at cycle 3 of SHIFT with different operands → ignored; the first result completes unchanged at cycle 8, and only one `done` pulse occurs.
- `start` held high across `done` → second operation accepted in DONE; second `done` 9 cycles after the first.
- `rst_n` low at cycle 4 of SHIFT → `busy`=0 immediately, `sum`=0, no `done`. After release, a new 0x10+0x20 yields 0x30.
